// File: rtl/sync_stream_mem_pkg.sv
// ============================================================================
// Module  : sync_stream_mem_pkg
// Brief   : Shared helpers for the credit-tracked streaming memory slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_stream_mem_pkg;

  // Pointer increment with wrap at an arbitrary (non power-of-2) modulus.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned modulus);
    return (ptr + 1 >= modulus) ? 0 : ptr + 1;
  endfunction

  // A new request may issue only if every buffered and in-flight word still fits.
  function automatic logic credit_avail(input int unsigned occ, input int unsigned inflight,
                                        input int unsigned els);
    return (occ + inflight) < els;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_1r1w_sync.sv
// ============================================================================
// Module  : ram_1r1w_sync
// Brief   : One-read one-write synchronous RAM, read-first on address collision.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_1r1w_sync #(
  parameter int width_p    = 4,
  parameter int depth_p    = 4,
  parameter     filename_p = "unknown.txt"
) (
  input  logic                       clk_i,
  input  logic                       r_v_i,
  input  logic [$clog2(depth_p)-1:0] r_addr_i,
  output logic [width_p-1:0]         r_data_o,
  input  logic                       w_v_i,
  input  logic [$clog2(depth_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]         w_data_i
);

  if (depth_p < 2) begin : g_bad_depth
    $error("ram_1r1w_sync (%s): depth_p must be at least 2", filename_p);
  end

  logic [width_p-1:0] mem_r [depth_p];

  // Storage is deliberately not reset; contents survive a block reset.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
    if (r_v_i) r_data_o <= mem_r[r_addr_i];
  end

endmodule

`default_nettype wire

// File: rtl/stream_resp_fifo.sv
// ============================================================================
// Module  : stream_resp_fifo
// Brief   : Small circular response FIFO with occupancy output; any depth >= 2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_resp_fifo
  import sync_stream_mem_pkg::*;
#(
  parameter int width_p = 4,
  parameter int els_p   = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         pop_i,
  output logic [width_p-1:0]           data_o,
  output logic [$clog2(els_p+1)-1:0]   occ_o
);

  localparam int PTR_W = $clog2(els_p);
  localparam int OCC_W = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic               do_pop;

  // The caller guarantees space for every push; pops on empty are ignored.
  assign do_pop = pop_i && (occ_r != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else begin
      if (push_i) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= PTR_W'(wrap_inc(32'(wr_ptr_r), els_p));
      end
      if (do_pop) rd_ptr_r <= PTR_W'(wrap_inc(32'(rd_ptr_r), els_p));
      if (push_i && !do_pop)      occ_r <= occ_r + OCC_W'(1);
      else if (!push_i && do_pop) occ_r <= occ_r - OCC_W'(1);
    end
  end

  assign data_o = mem_r[rd_ptr_r];
  assign occ_o  = occ_r;

endmodule

`default_nettype wire

// File: rtl/sync_stream_mem.sv
// ============================================================================
// Module  : sync_stream_mem
// Brief   : 1R1W memory with valid/ready read request and credit-tracked response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_stream_mem
  import sync_stream_mem_pkg::*;
#(
  parameter int width_p    = 4,
  parameter int depth_p    = 4,
  parameter     filename_p = "unknown.txt",
  parameter int els_p      = 3,
  parameter int bypass_p   = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rd_addr_valid_i,
  input  logic [$clog2(depth_p)-1:0] rd_addr_i,
  output logic                       rd_addr_ready_o,
  output logic                       rd_data_valid_o,
  output logic [width_p-1:0]         rd_data_o,
  input  logic                       rd_data_ready_i,
  input  logic                       wr_valid_i,
  input  logic [$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [width_p-1:0]         wr_data_i
);

  localparam int OCC_W = $clog2(els_p + 1);

  if (els_p < 2) begin : g_bad_els
    $error("sync_stream_mem: els_p must be at least 2");
  end

  logic               accept;
  logic               collide;
  logic               inflight_r;
  logic               byp_r;
  logic [width_p-1:0] byp_data_r;
  logic [width_p-1:0] ram_data;
  logic [width_p-1:0] push_data;
  logic [OCC_W-1:0]   occ_r;

  // Ready depends on registered state only, never on rd_data_ready_i.
  assign rd_addr_ready_o = credit_avail(32'(occ_r), 32'(inflight_r), els_p);
  assign accept          = rd_addr_valid_i && rd_addr_ready_o;
  assign collide         = (bypass_p != 0) && wr_valid_i && (wr_addr_i == rd_addr_i);
  assign push_data       = byp_r ? byp_data_r : ram_data;
  assign rd_data_valid_o = (occ_r != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inflight_r <= 1'b0;
      byp_r      <= 1'b0;
      byp_data_r <= '0;
    end else begin
      inflight_r <= accept;
      if (accept) begin
        byp_r      <= collide;
        byp_data_r <= wr_data_i;
      end
    end
  end

  ram_1r1w_sync #(
    .width_p    (width_p),
    .depth_p    (depth_p),
    .filename_p (filename_p)
  ) u_ram (
    .clk_i    (clk_i),
    .r_v_i    (accept),
    .r_addr_i (rd_addr_i),
    .r_data_o (ram_data),
    .w_v_i    (wr_valid_i),
    .w_addr_i (wr_addr_i),
    .w_data_i (wr_data_i)
  );

  stream_resp_fifo #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (inflight_r),
    .data_i  (push_data),
    .pop_i   (rd_data_ready_i),
    .data_o  (rd_data_o),
    .occ_o   (occ_r)
  );

endmodule

`default_nettype wire

// File: tb/tb_sync_stream_mem.sv
// ============================================================================
// Module  : tb_sync_stream_mem
// Brief   : Scoreboard bench: default, bypass_p=0 and els_p=2 instances side by side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_stream_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rv [3];
  logic [1:0] ra [3];
  logic       rr [3];
  logic       wv [3];
  logic [1:0] wa [3];
  logic [3:0] wd [3];
  logic       ar [3];
  logic       dv [3];
  logic [3:0] dd [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cnt [3];
  int pop_cnt [3];
  bit lat_chk [3];

  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults; 1: read-first on collision; 2: two-entry buffer.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int BYP = (k == 1) ? 0 : 1;
    localparam int ELS = (k == 2) ? 2 : 3;

    sync_stream_mem #(
      .width_p(4), .depth_p(4), .filename_p("unknown.txt"), .els_p(ELS), .bypass_p(BYP)
    ) dut (
      .clk_i(clk), .reset_i(rst),
      .rd_addr_valid_i(rv[k]), .rd_addr_i(ra[k]), .rd_addr_ready_o(ar[k]),
      .rd_data_valid_o(dv[k]), .rd_data_o(dd[k]), .rd_data_ready_i(rr[k]),
      .wr_valid_i(wv[k]), .wr_addr_i(wa[k]), .wr_data_i(wd[k])
    );

    logic [3:0] mm [4];
    logic [3:0] q_data [$];
    int         q_cyc  [$];
    logic       hold   = 1'b0;
    logic [3:0] hold_d = '0;

    // Issue side: memory model sees the read before the same-edge write.
    always @(negedge clk) begin : trk
      logic [3:0] e;
      if (!rst) begin
        if (rv[k] && ar[k] === 1'b1) begin
          if (BYP != 0 && wv[k] && wa[k] == ra[k]) e = wd[k];
          else                                     e = mm[ra[k]];
          q_data.push_back(e);
          q_cyc.push_back(cyc);
          acc_cnt[k]++;
        end
        if (wv[k]) mm[wa[k]] = wd[k];
      end
    end

    always @(negedge clk or posedge rst) begin : mon
      logic [3:0] e;
      int         c;
      if (rst) begin
        pop_cnt[k] += q_data.size();
        q_data.delete();
        q_cyc.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          checks++;
          if (dv[k] !== 1'b1 || dd[k] !== hold_d) begin
            errors++;
            $display("FAIL stall_hold dut%0d actual valid=%0b data=%0d required valid=1 data=%0d",
                     k, dv[k], dd[k], hold_d);
          end
        end
        if (dv[k] === 1'b1 && rr[k]) begin
          pop_cnt[k]++;
          checks++;
          if (q_data.size() == 0) begin
            errors++;
            $display("FAIL spurious_resp dut%0d actual data=%0d required no response", k, dd[k]);
          end else begin
            e = q_data.pop_front();
            c = q_cyc.pop_front();
            if (dd[k] !== e) begin
              errors++;
              $display("FAIL resp_data dut%0d actual=%0d required=%0d", k, dd[k], e);
            end
            if (lat_chk[k]) begin
              checks++;
              if (cyc != c + 2) begin
                errors++;
                $display("FAIL latency dut%0d actual=%0d required=2", k, cyc - c);
              end
            end
          end
        end
        hold   = (dv[k] === 1'b1) && !rr[k];
        hold_d = dd[k];
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0; wv[k] = 1'b0; rr[k] = 1'b1;
    end
  endtask

  int sent, first_pop, fourth, win;

  initial begin
    for (int k = 0; k < 3; k++) begin
      ra[k] = '0; wa[k] = '0; wd[k] = '0; lat_chk[k] = 1'b0;
    end
    idle_all();

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", k, ar[k], 1);
      chk("reset_valid", k, dv[k], 0);
      chk("reset_data",  k, dd[k], 0);
    end
    tick();
    rst = 1'b0;

    // Preload mem[a] = a+1 through the write port.
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k < 3; k++) begin
        wv[k] = 1'b1; wa[k] = 2'(a); wd[k] = 4'(a + 1);
      end
      tick();
    end
    idle_all();

    // Back-to-back reads, consumer always ready.
    for (int k = 0; k < 3; k++) lat_chk[k] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rv[0] = (i < 4); ra[0] = 2'(i);
      @(negedge clk);
      if (i < 4) chk("t1_ready", 0, ar[0], 1);
      if (i >= 2) begin
        chk("t1_valid", 0, dv[0], 1);
        chk("t1_data",  0, dd[0], i - 1);
      end
      tick();
    end
    rv[0] = 1'b0;
    repeat (3) tick();

    // Full backpressure, then drain.
    for (int k = 0; k < 3; k++) lat_chk[k] = 1'b0;
    rr[0] = 1'b0;
    sent  = 0;
    for (int i = 0; i < 8; i++) begin
      rv[0] = (sent < 5); ra[0] = 2'(sent);
      @(negedge clk);
      if (rv[0] && ar[0]) sent++;
      tick();
    end
    chk("t2_accepted", 0, sent, 3);
    chk("t2_ready_low", 0, ar[0], 0);
    rr[0] = 1'b1; first_pop = -1; fourth = -1;
    for (int i = 0; i < 12; i++) begin
      rv[0] = (sent < 5); ra[0] = 2'(sent);
      @(negedge clk);
      if (dv[0] && first_pop < 0) first_pop = cyc;
      if (rv[0] && ar[0]) begin
        if (sent == 3) fourth = cyc;
        sent++;
      end
      tick();
    end
    rv[0] = 1'b0;
    chk("t2_all_sent", 0, sent, 5);
    chk("t2_reaccept", 0, fourth, first_pop + 1);

    // Random traffic on every instance.
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 3; k++) begin
        rv[k] = 1'($urandom_range(0, 1));
        ra[k] = 2'($urandom_range(0, 3));
        rr[k] = ($urandom_range(0, 2) != 0);
        wv[k] = ($urandom_range(0, 3) == 0);
        wa[k] = 2'($urandom_range(0, 3));
        wd[k] = 4'($urandom);
      end
      tick();
    end
    idle_all();
    repeat (10) tick();
    for (int k = 0; k < 3; k++) chk("t3_drained", k, pop_cnt[k], acc_cnt[k]);

    // Collision: write 9 to addr 2 while reading addr 2, old value 5.
    for (int k = 0; k < 3; k++) lat_chk[k] = 1'b1;
    for (int k = 0; k < 3; k++) begin wv[k] = 1'b1; wa[k] = 2'd2; wd[k] = 4'd5; end
    tick();
    for (int k = 0; k < 3; k++) begin wd[k] = 4'd9; rv[k] = 1'b1; ra[k] = 2'd2; end
    tick();
    for (int k = 0; k < 3; k++) wv[k] = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) rv[k] = 1'b0;
    @(negedge clk);
    chk("t4_bypass_new", 0, dd[0], 9);
    chk("t4_readfirst_old", 1, dd[1], 5);
    chk("t4_bypass_new", 2, dd[2], 9);
    tick();
    @(negedge clk);
    chk("t4_followup", 1, dd[1], 9);
    chk("t4_followup", 0, dd[0], 9);
    tick();
    repeat (3) tick();

    // Asynchronous reset with two buffered and one in flight.
    for (int k = 0; k < 3; k++) begin lat_chk[k] = 1'b0; rr[k] = 1'b0; end
    for (int i = 0; i < 3; i++) begin
      rv[0] = 1'b1; ra[0] = 2'(i);
      tick();
    end
    rv[0] = 1'b0;
    chk("t5_buffered", 0, dv[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 0, dv[0], 0);
    chk("t5_rst_data",  0, dd[0], 0);
    chk("t5_rst_ready", 0, ar[0], 1);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_resp", 0, dv[0], 0);
    end
    tick();
    for (int k = 0; k < 3; k++) begin rr[k] = 1'b1; lat_chk[k] = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      rv[0] = 1'b1; ra[0] = 2'(i);
      tick();
    end
    rv[0] = 1'b0;
    repeat (5) tick();

    // Two-entry buffer: two accepts in every three cycles.
    win = 0;
    for (int j = 0; j < 30; j++) begin
      rv[2] = 1'b1; ra[2] = 2'(j);
      @(negedge clk);
      if (ar[2]) win++;
      if (j % 3 == 2) begin
        chk("t6_window", 2, win, 2);
        win = 0;
      end
      tick();
    end
    rv[2] = 1'b0;
    repeat (6) tick();

    for (int k = 0; k < 3; k++) chk("final_drained", k, pop_cnt[k], acc_cnt[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
